sdram_burst_writer: RTL and testbench

Parametrised FIFO-to-SDRAM write engine that sits between the USB/CYP receive FIFO (show-ahead read side) and the SDRAM controller write port. It pops the FIFO in fixed-length bursts, presents each beat on a valid/ready interface with an incrementing, wrapping byte address, and marks the last beat of every burst. Compared with the first-generation writer, it adds:

- a FIFO-level burst trigger in place of the fixed wait;
- true backpressure handling;
- partial-burst flush;
- a bounded address region;
- an explicit address clear.

---
 rtl/sdram_burst_writer_pkg.sv | 14 +
 rtl/sdram_burst_writer_addr_gen.sv | 91 +++++++++
 rtl/sdram_burst_writer.sv | 141 ++++++++++++++
 tb/tb_sdram_burst_writer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_burst_writer_pkg.sv
// Shared definitions for the SDRAM write engines: FSM encoding and default burst/timing constants.
package sdram_burst_writer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBurst = 2'd1,
        StDrain = 2'd2
    } wr_state_e;

    localparam int unsigned DefBurstLen    = 8;
    localparam int unsigned DefFlushWait   = 47;
    localparam int unsigned DefIdleTimeout = 133_000_000;

endpackage

// File: rtl/sdram_burst_writer_addr_gen.sv
// Write-address generator: per-beat region wrap, deferred address clear and idle timeout.
module sdram_burst_writer_addr_gen
    import sdram_burst_writer_pkg::*;
#(
    parameter int unsigned   AW           = 32,
    parameter int unsigned   ADDR_STEP    = 2,
    parameter logic [AW-1:0] BASE_ADDR    = '0,
    parameter logic [AW-1:0] REGION_BYTES = AW'(32'h0200_0000),
    parameter int unsigned   IDLE_TIMEOUT = DefIdleTimeout
) (
    input  logic          sdram_clk,
    input  logic          rst_n,
    input  logic          accept_i,
    input  logic          in_idle_i,
    input  logic          enter_idle_i,
    input  logic          fifo_rempty_i,
    input  logic          addr_clr_i,
    output logic [AW-1:0] wr_addr_o,
    output logic          wrap_pulse_o,
    output logic          timeout_pulse_o
);

    localparam logic [AW-1:0] RegionEnd = BASE_ADDR + REGION_BYTES;

    logic [AW-1:0] addr_q, addr_d, addr_inc;
    logic [31:0]   tmo_cnt_q, tmo_cnt_d;
    logic          pend_q, pend_d;
    logic          wrap_q, wrap_d;
    logic          tmo_q;
    logic          tmo_fire, clr, wraps;

    assign addr_inc = addr_q + AW'(ADDR_STEP);
    assign wraps    = (addr_inc == RegionEnd);

    // Saturating counter; holding at IDLE_TIMEOUT is what keeps the pulse single-shot.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (!in_idle_i || !fifo_rempty_i) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != IDLE_TIMEOUT) begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
    end

    assign tmo_fire = (tmo_cnt_d == IDLE_TIMEOUT) && (tmo_cnt_q != IDLE_TIMEOUT);

    // A clear takes priority over the accept that closes a burst.
    assign clr = (in_idle_i && addr_clr_i) || (enter_idle_i && (pend_q || addr_clr_i)) || tmo_fire;

    always_comb begin
        addr_d = addr_q;
        wrap_d = 1'b0;
        pend_d = pend_q;
        if (enter_idle_i || clr) begin
            pend_d = 1'b0;
        end else if (!in_idle_i && addr_clr_i) begin
            pend_d = 1'b1;
        end
        if (clr) begin
            addr_d = BASE_ADDR;
        end else if (accept_i) begin
            if (wraps) begin
                addr_d = BASE_ADDR;
                wrap_d = 1'b1;
            end else begin
                addr_d = addr_inc;
            end
        end
    end

    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= BASE_ADDR;
            tmo_cnt_q <= '0;
            pend_q    <= 1'b0;
            wrap_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            tmo_cnt_q <= tmo_cnt_d;
            pend_q    <= pend_d;
            wrap_q    <= wrap_d;
            tmo_q     <= tmo_fire;
        end
    end

    assign wr_addr_o       = addr_q;
    assign wrap_pulse_o    = wrap_q;
    assign timeout_pulse_o = tmo_q;

endmodule

// File: rtl/sdram_burst_writer.sv
// FIFO-to-SDRAM burst write engine: pops a show-ahead FIFO in bursts and presents beats on a
// valid/ready write port with backpressure, partial-burst flush and a bounded address region.
module sdram_burst_writer
    import sdram_burst_writer_pkg::*;
#(
    parameter int unsigned   DW           = 16,
    parameter int unsigned   AW           = 32,
    parameter int unsigned   CW           = 10,
    parameter int unsigned   BURST_LEN    = DefBurstLen,
    parameter int unsigned   ADDR_STEP    = DW / 8,
    parameter logic [AW-1:0] BASE_ADDR    = '0,
    parameter logic [AW-1:0] REGION_BYTES = AW'(32'h0200_0000),
    parameter int unsigned   FLUSH_WAIT   = DefFlushWait,
    parameter int unsigned   IDLE_TIMEOUT = DefIdleTimeout
) (
    input  logic          sdram_clk,
    input  logic          rst_n,
    output logic          fifo_ren,
    input  logic [DW-1:0] fifo_rdata,
    input  logic          fifo_rempty,
    input  logic [CW-1:0] fifo_rcount,
    input  logic          addr_clr,
    output logic [DW-1:0] wr_data,
    output logic [AW-1:0] wr_addr,
    output logic          wr_valid,
    output logic          wr_last,
    input  logic          wr_ready,
    output logic          busy,
    output logic          wrap_pulse,
    output logic          timeout_pulse
);

    wr_state_e     state_q, state_d;
    logic [CW-1:0] beats_left_q, beats_left_d;
    logic [31:0]   flush_cnt_q, flush_cnt_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          wr_valid_q, wr_valid_d;
    logic          wr_last_q, wr_last_d;
    logic          pop, accept, enter_idle, in_idle;

    assign accept     = wr_valid_q && wr_ready;
    assign in_idle    = (state_q == StIdle);
    assign enter_idle = (state_q == StDrain) && accept;

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        flush_cnt_d  = flush_cnt_q;
        wr_data_d    = wr_data_q;
        wr_valid_d   = wr_valid_q;
        wr_last_d    = wr_last_q;
        pop          = 1'b0;
        case (state_q)
            StIdle: begin
                if (fifo_rempty) begin
                    flush_cnt_d = '0;
                end else if (flush_cnt_q != FLUSH_WAIT) begin
                    flush_cnt_d = flush_cnt_q + 32'd1;
                end
                if (fifo_rcount >= CW'(BURST_LEN)) begin
                    state_d      = StBurst;
                    beats_left_d = CW'(BURST_LEN);
                    flush_cnt_d  = '0;
                end else if ((FLUSH_WAIT != 0) && (fifo_rcount != '0) &&
                             (flush_cnt_q == FLUSH_WAIT)) begin
                    state_d      = StBurst;
                    beats_left_d = fifo_rcount;
                    flush_cnt_d  = '0;
                end
            end
            StBurst: begin
                // Pop only into an empty or draining output register.
                pop = !fifo_rempty && (beats_left_q != '0) && (!wr_valid_q || wr_ready);
                if (pop) begin
                    wr_data_d    = fifo_rdata;
                    wr_valid_d   = 1'b1;
                    wr_last_d    = (beats_left_q == CW'(1));
                    beats_left_d = beats_left_q - CW'(1);
                    if (beats_left_q == CW'(1)) begin
                        state_d = StDrain;
                    end
                end else if (accept) begin
                    wr_valid_d = 1'b0;
                    wr_last_d  = 1'b0;
                end
            end
            StDrain: begin
                if (accept) begin
                    wr_valid_d = 1'b0;
                    wr_last_d  = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            beats_left_q <= '0;
            flush_cnt_q  <= '0;
            wr_data_q    <= '0;
            wr_valid_q   <= 1'b0;
            wr_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            flush_cnt_q  <= flush_cnt_d;
            wr_data_q    <= wr_data_d;
            wr_valid_q   <= wr_valid_d;
            wr_last_q    <= wr_last_d;
        end
    end

    sdram_burst_writer_addr_gen #(
        .AW           (AW),
        .ADDR_STEP    (ADDR_STEP),
        .BASE_ADDR    (BASE_ADDR),
        .REGION_BYTES (REGION_BYTES),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_addr_gen (
        .sdram_clk       (sdram_clk),
        .rst_n           (rst_n),
        .accept_i        (accept),
        .in_idle_i       (in_idle),
        .enter_idle_i    (enter_idle),
        .fifo_rempty_i   (fifo_rempty),
        .addr_clr_i      (addr_clr),
        .wr_addr_o       (wr_addr),
        .wrap_pulse_o    (wrap_pulse),
        .timeout_pulse_o (timeout_pulse)
    );

    assign fifo_ren = pop;
    assign wr_data  = wr_data_q;
    assign wr_valid = wr_valid_q;
    assign wr_last  = wr_last_q;
    assign busy     = !in_idle;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Directed bench for sdram_burst_writer with a behavioural show-ahead FIFO and a beat log.
module tb_sdram_burst_writer;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 10;

    logic          sdram_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_ren;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rempty;
    logic [CW-1:0] fifo_rcount;
    logic          addr_clr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_valid;
    logic          wr_last;
    logic          wr_ready;
    logic          busy;
    logic          wrap_pulse;
    logic          timeout_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [DW-1:0] fifo_mem[$];
    logic [AW-1:0] beat_addr[64];
    logic [DW-1:0] beat_data[64];
    logic          beat_last[64];
    int            beat_cyc[64];
    int            nbeats;

    logic          pop_pend, busy_prev, prev_stall, prev_last;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    int            busy_rise, busy_fall, last_ren, wrap_cnt, wrap_at, tmo_cnt, tmo_cyc;
    int            c0;
    logic [3:0]    ready_pat;

    sdram_burst_writer #(
        .DW           (16),
        .AW           (32),
        .CW           (10),
        .BURST_LEN    (8),
        .ADDR_STEP    (2),
        .BASE_ADDR    (32'h0),
        .REGION_BYTES (32'd32),
        .FLUSH_WAIT   (47),
        .IDLE_TIMEOUT (100)
    ) dut (
        .sdram_clk     (sdram_clk),
        .rst_n         (rst_n),
        .fifo_ren      (fifo_ren),
        .fifo_rdata    (fifo_rdata),
        .fifo_rempty   (fifo_rempty),
        .fifo_rcount   (fifo_rcount),
        .addr_clr      (addr_clr),
        .wr_data       (wr_data),
        .wr_addr       (wr_addr),
        .wr_valid      (wr_valid),
        .wr_last       (wr_last),
        .wr_ready      (wr_ready),
        .busy          (busy),
        .wrap_pulse    (wrap_pulse),
        .timeout_pulse (timeout_pulse)
    );

    always #5 sdram_clk = ~sdram_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic fifo_sync();
        fifo_rempty = (fifo_mem.size() == 0);
        fifo_rcount = CW'(fifo_mem.size());
        fifo_rdata  = (fifo_mem.size() != 0) ? fifo_mem[0] : '0;
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_mem.push_back(base + DW'(i));
        fifo_sync();
    endtask

    // One clock: monitor at the falling edge, then apply the pop the DUT made at the rising edge.
    task automatic step();
        @(negedge sdram_clk);
        if (prev_stall) begin
            check("stall_valid", wr_valid, 1'b1);
            check("stall_data", wr_data, prev_data);
            check("stall_addr", wr_addr, prev_addr);
            check("stall_last", wr_last, prev_last);
        end
        if (wr_valid && !wr_ready) check("stall_no_pop", fifo_ren, 1'b0);
        prev_stall = wr_valid && !wr_ready;
        prev_data  = wr_data;
        prev_addr  = wr_addr;
        prev_last  = wr_last;
        if (wrap_pulse) begin
            wrap_cnt++;
            wrap_at = nbeats;
        end
        if (timeout_pulse) begin
            tmo_cnt++;
            tmo_cyc = cyc;
        end
        if (busy && !busy_prev) busy_rise = cyc;
        if (!busy && busy_prev) busy_fall = cyc;
        busy_prev = busy;
        if (fifo_ren) last_ren = cyc;
        pop_pend = fifo_ren;
        if (wr_valid && wr_ready && nbeats < 64) begin
            beat_addr[nbeats] = wr_addr;
            beat_data[nbeats] = wr_data;
            beat_last[nbeats] = wr_last;
            beat_cyc[nbeats]  = cyc;
            nbeats++;
        end
        @(posedge sdram_clk);
        cyc++;
        #1;
        if (pop_pend && rst_n && fifo_mem.size() != 0) begin
            fifo_mem.delete(0);
            fifo_sync();
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        wr_ready = 1'b0;
        addr_clr = 1'b0;
        fifo_mem.delete();
        fifo_sync();
        pop_pend   = 1'b0;
        busy_prev  = 1'b0;
        prev_stall = 1'b0;
        nbeats     = 0;
        busy_rise  = -1;
        busy_fall  = -1;
        last_ren   = -1;
        wrap_cnt   = 0;
        wrap_at    = -1;
        tmo_cnt    = 0;
        tmo_cyc    = -1;
        repeat (2) @(posedge sdram_clk);
        #2 rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (nbeats < n && k < budget) begin
            step();
            k++;
        end
        check("beats_seen", nbeats, n);
    endtask

    initial begin
        ready_pat = 4'b1001;

        // Reset values
        do_reset();
        check("rst_addr", wr_addr, 32'h0);
        check("rst_data", wr_data, 16'h0);
        check("rst_valid", wr_valid, 1'b0);
        check("rst_last", wr_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ren", fifo_ren, 1'b0);
        check("rst_wrap", wrap_pulse, 1'b0);
        check("rst_tmo", timeout_pulse, 1'b0);

        // Full burst at full throughput
        do_reset();
        wr_ready = 1'b1;
        c0 = cyc;
        push_words(16'h0001, 8);
        wait_beats(8, 40);
        for (int i = 0; i < 8; i++) begin
            check("t1_addr", beat_addr[i], 64'(2 * i));
            check("t1_data", beat_data[i], 64'(i + 1));
            check("t1_last", beat_last[i], (i == 7));
            check("t1_cycle", beat_cyc[i], 64'(c0 + 2 + i));
        end
        repeat (3) step();
        check("t1_busy_fall", busy_fall - last_ren, 2);

        // Backpressure with ready pattern 1,0,0,1
        do_reset();
        push_words(16'h0010, 8);
        for (int k = 0; k < 40; k++) begin
            wr_ready = ready_pat[k % 4];
            step();
        end
        wr_ready = 1'b1;
        wait_beats(8, 30);
        repeat (3) step();
        check("t2_no_dup", nbeats, 8);
        check("t2_fifo_empty", fifo_mem.size(), 0);
        for (int i = 0; i < 8; i++) begin
            check("t2_addr", beat_addr[i], 64'(2 * i));
            check("t2_data", beat_data[i], 64'(16'h0010 + i));
            check("t2_last", beat_last[i], (i == 7));
        end

        // Partial flush after FLUSH_WAIT, then a full burst continues the address
        do_reset();
        wr_ready = 1'b1;
        c0 = cyc;
        push_words(16'h00A1, 3);
        wait_beats(3, 80);
        check("t3_start", busy_rise - c0, 48);
        for (int i = 0; i < 3; i++) begin
            check("t3_addr", beat_addr[i], 64'(2 * i));
            check("t3_data", beat_data[i], 64'(16'h00A1 + i));
            check("t3_last", beat_last[i], (i == 2));
        end
        push_words(16'h00B0, 8);
        wait_beats(11, 40);
        check("t3_next_addr", beat_addr[3], 32'h6);
        check("t3_end_addr", beat_addr[10], 32'h14);
        check("t3_end_last", beat_last[10], 1'b1);

        // Region wrap at 32 bytes
        do_reset();
        wr_ready = 1'b1;
        push_words(16'h0100, 24);
        wait_beats(24, 200);
        for (int i = 0; i < 24; i++) begin
            check("t4_addr", beat_addr[i], 64'((i < 16) ? 2 * i : 2 * (i - 16)));
            check("t4_data", beat_data[i], 64'(16'h0100 + i));
        end
        repeat (2) step();
        check("t4_wrap_cnt", wrap_cnt, 1);
        check("t4_wrap_at", wrap_at, 16);

        // Address clear mid-burst applies to the next burst only
        do_reset();
        wr_ready = 1'b1;
        push_words(16'h00C0, 8);
        for (int k = 0; k < 40 && nbeats < 3; k++) step();
        addr_clr = 1'b1;
        step();
        addr_clr = 1'b0;
        wait_beats(8, 40);
        for (int i = 0; i < 8; i++) check("t5_addr_old", beat_addr[i], 64'(2 * i));
        repeat (3) step();
        check("t5_addr_cleared", wr_addr, 32'h0);
        push_words(16'h00D0, 8);
        wait_beats(16, 40);
        check("t5_new_addr0", beat_addr[8], 32'h0);
        check("t5_new_data0", beat_data[8], 16'h00D0);
        check("t5_new_addr7", beat_addr[15], 32'hE);

        // Idle timeout
        do_reset();
        wr_ready = 1'b1;
        push_words(16'h0200, 8);
        wait_beats(8, 40);
        repeat (3) step();
        for (int k = 0; k < 100 && cyc < busy_fall + 50; k++) step();
        check("t6_addr_hold", wr_addr, 32'h10);
        check("t6_no_early_tmo", tmo_cnt, 0);
        for (int k = 0; k < 300 && cyc < busy_fall + 200; k++) step();
        check("t6_tmo_cnt", tmo_cnt, 1);
        check("t6_tmo_delay", tmo_cyc - busy_fall, 100);
        check("t6_tmo_addr", wr_addr, 32'h0);

        // Reset mid-burst
        do_reset();
        wr_ready = 1'b1;
        push_words(16'h0300, 8);
        for (int k = 0; k < 40 && nbeats < 4; k++) step();
        check("t7_pre_valid", wr_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t7_valid", wr_valid, 1'b0);
        check("t7_last", wr_last, 1'b0);
        check("t7_data", wr_data, 16'h0);
        check("t7_addr", wr_addr, 32'h0);
        check("t7_busy", busy, 1'b0);
        check("t7_ren", fifo_ren, 1'b0);
        do_reset();
        wr_ready = 1'b1;
        push_words(16'h0400, 8);
        wait_beats(8, 40);
        check("t7_new_addr0", beat_addr[0], 32'h0);
        check("t7_new_data0", beat_data[0], 16'h0400);
        check("t7_new_addr7", beat_addr[7], 32'hE);
        check("t7_new_last7", beat_last[7], 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
